// File: rtl/ctrlport_to_jtag_multi_pkg.sv
// Register map, bitfields and engine state encoding for the multi-chain
// ControlPort JTAG master.
package ctrlport_to_jtag_multi_regs;

  localparam int NUM_ADDRESSES = 32;

  localparam logic [4:0] REG_TX_DATA  = 5'h00;
  localparam logic [4:0] REG_TMS_DATA = 5'h04;
  localparam logic [4:0] REG_CONTROL  = 5'h08;
  localparam logic [4:0] REG_RX_DATA  = 5'h0C;
  localparam logic [4:0] REG_ERROR    = 5'h10;

  localparam int PRESCALAR_POS   = 0;
  localparam int PRESCALAR_W     = 8;
  localparam int LENGTH_POS      = 8;
  localparam int LENGTH_W        = 5;
  localparam int SAMPLE_FALL_POS = 13;
  localparam int CHANNEL_POS     = 16;
  localparam int CHANNEL_W       = 4;
  localparam int RESET_POS       = 31;
  localparam int READY_POS       = 31;

  localparam int ERR_BUSY_BIT    = 0;
  localparam int ERR_CHANNEL_BIT = 1;
  localparam int ERROR_W         = 2;

  localparam logic [1:0] STS_OKAY   = 2'd0;
  localparam logic [1:0] STS_CMDERR = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } jtag_state_t;

  function automatic logic [31:0] pack_control(
    input logic                   ready,
    input logic [PRESCALAR_W-1:0] prescalar,
    input logic [LENGTH_W-1:0]    length,
    input logic                   sample_fall,
    input logic [CHANNEL_W-1:0]   channel
  );
    pack_control = '0;
    pack_control[READY_POS]                        = ready;
    pack_control[PRESCALAR_POS +: PRESCALAR_W]     = prescalar;
    pack_control[LENGTH_POS +: LENGTH_W]           = length;
    pack_control[SAMPLE_FALL_POS]                  = sample_fall;
    pack_control[CHANNEL_POS +: CHANNEL_W]         = channel;
  endfunction

endpackage

// File: rtl/ctrlport_to_jtag_multi_shift_engine.sv
// JTAG shift engine: prescaled TCK generation, TDI/TMS drive and TDO capture
// on one selectable chain out of NUM_CHANNELS.
module jtag_shift_engine
  import ctrlport_to_jtag_multi_regs::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter bit IDLE_TCK     = 1'b0
) (
  input  logic                    ctrlport_clk,
  input  logic                    ctrlport_rst,
  input  logic                    start,
  input  logic                    soft_rst,
  input  logic [31:0]             tx_data,
  input  logic [31:0]             tms_data,
  input  logic [PRESCALAR_W-1:0]  prescalar,
  input  logic [LENGTH_W-1:0]     length,
  input  logic                    sample_fall,
  input  logic [CHANNEL_W-1:0]    channel,
  output logic                    ready,
  output logic [31:0]             rx_data,
  output logic [NUM_CHANNELS-1:0] tck,
  output logic [NUM_CHANNELS-1:0] tdi,
  output logic [NUM_CHANNELS-1:0] tms,
  input  logic [NUM_CHANNELS-1:0] tdo
);

  jtag_state_t            state_reg;
  logic [PRESCALAR_W-1:0] phase_cnt_reg;
  logic [PRESCALAR_W-1:0] presc_reg;
  logic [LENGTH_W-1:0]    bit_cnt_reg;
  logic [LENGTH_W-1:0]    length_reg;
  logic [LENGTH_W-1:0]    bit_next;
  logic [31:0]            tx_bits_reg;
  logic [31:0]            tms_bits_reg;
  logic [31:0]            rx_shift_reg;
  logic [31:0]            rx_data_reg;
  logic [CHANNEL_W-1:0]   channel_reg;
  logic                   sample_fall_reg;
  logic                   tck_bit_reg;
  logic                   tdi_bit_reg;
  logic                   tms_bit_reg;
  logic                   ready_reg;
  logic                   phase_done;
  logic                   capture_now;
  logic                   tdo_sel;

  logic [NUM_CHANNELS-1:0] chan_sel;
  logic [NUM_CHANNELS-1:0] tdo_hit;

  // Unselected chains see constant idle levels; only the latched chain follows the engine.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    assign chan_sel[gi] = (channel_reg == CHANNEL_W'(gi));
    assign tck[gi]      = chan_sel[gi] ? tck_bit_reg : IDLE_TCK;
    assign tdi[gi]      = chan_sel[gi] & tdi_bit_reg;
    assign tms[gi]      = chan_sel[gi] & tms_bit_reg;
    assign tdo_hit[gi]  = chan_sel[gi] & tdo[gi];
  end

  assign tdo_sel     = |tdo_hit;
  assign phase_done  = (phase_cnt_reg == presc_reg);
  assign bit_next    = bit_cnt_reg + 5'd1;
  assign capture_now = (state_reg == ST_HIGH) &&
                       (sample_fall_reg ? phase_done : (phase_cnt_reg == '0));

  always_ff @(posedge ctrlport_clk) begin
    if (ctrlport_rst || soft_rst) begin
      state_reg     <= ST_IDLE;
      phase_cnt_reg <= '0;
      bit_cnt_reg   <= '0;
      tck_bit_reg   <= IDLE_TCK;
      tdi_bit_reg   <= 1'b0;
      tms_bit_reg   <= 1'b0;
      // A soft reset leaves ready low for one more cycle; IDLE raises it.
      if (ctrlport_rst) begin
        ready_reg       <= 1'b1;
        channel_reg     <= '0;
        presc_reg       <= '0;
        length_reg      <= '0;
        sample_fall_reg <= 1'b0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          ready_reg <= 1'b1;
          if (start) begin
            tx_bits_reg     <= tx_data;
            tms_bits_reg    <= tms_data;
            presc_reg       <= prescalar;
            length_reg      <= length;
            sample_fall_reg <= sample_fall;
            channel_reg     <= channel;
            rx_shift_reg    <= '0;
            bit_cnt_reg     <= '0;
            phase_cnt_reg   <= '0;
            tck_bit_reg     <= 1'b0;
            tdi_bit_reg     <= tx_data[0];
            tms_bit_reg     <= tms_data[0];
            ready_reg       <= 1'b0;
            state_reg       <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (phase_done) begin
            phase_cnt_reg <= '0;
            tck_bit_reg   <= 1'b1;
            state_reg     <= ST_HIGH;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 8'd1;
          end
        end
        ST_HIGH: begin
          if (capture_now) rx_shift_reg[bit_cnt_reg] <= tdo_sel;
          if (phase_done) begin
            phase_cnt_reg <= '0;
            if (bit_cnt_reg == length_reg) begin
              tck_bit_reg <= IDLE_TCK;
              tdi_bit_reg <= 1'b0;
              tms_bit_reg <= 1'b0;
              state_reg   <= ST_DONE;
            end else begin
              bit_cnt_reg <= bit_next;
              tck_bit_reg <= 1'b0;
              tdi_bit_reg <= tx_bits_reg[bit_next];
              tms_bit_reg <= tms_bits_reg[bit_next];
              state_reg   <= ST_LOW;
            end
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 8'd1;
          end
        end
        ST_DONE: begin
          rx_data_reg <= rx_shift_reg;
          ready_reg   <= 1'b1;
          state_reg   <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ready   = ready_reg;
  assign rx_data = rx_data_reg;

endmodule

// File: rtl/ctrlport_to_jtag_multi.sv
// ControlPort register window for a multi-chain JTAG master; decodes requests,
// holds the configuration/error registers and launches the shift engine.
module ctrlport_to_jtag_multi
  import ctrlport_to_jtag_multi_regs::*;
#(
  parameter int BASE_ADDRESS      = 0,
  parameter int NUM_CHANNELS      = 2,
  parameter int DEFAULT_PRESCALAR = 0,
  parameter bit IDLE_TCK          = 1'b0
) (
  input  logic                    ctrlport_clk,
  input  logic                    ctrlport_rst,
  input  logic                    s_ctrlport_req_wr,
  input  logic                    s_ctrlport_req_rd,
  input  logic [19:0]             s_ctrlport_req_addr,
  input  logic [31:0]             s_ctrlport_req_data,
  output logic                    s_ctrlport_resp_ack,
  output logic [1:0]              s_ctrlport_resp_status,
  output logic [31:0]             s_ctrlport_resp_data,
  output logic [NUM_CHANNELS-1:0] tck,
  output logic [NUM_CHANNELS-1:0] tdi,
  output logic [NUM_CHANNELS-1:0] tms,
  input  logic [NUM_CHANNELS-1:0] tdo
);

  localparam logic [19:0] BASE_ADDR = 20'(BASE_ADDRESS);
  localparam logic [4:0]  NUM_CH    = 5'(NUM_CHANNELS);

  logic [31:0]            tx_reg;
  logic [31:0]            tms_reg;
  logic [PRESCALAR_W-1:0] presc_reg;
  logic [LENGTH_W-1:0]    length_reg;
  logic                   sample_fall_reg;
  logic [CHANNEL_W-1:0]   channel_reg;
  logic [ERROR_W-1:0]     err_reg;
  logic                   start_reg;
  logic                   soft_rst_reg;
  logic                   resp_ack_reg;
  logic [1:0]             resp_status_reg;
  logic [31:0]            resp_data_reg;

  logic [19:0]          offset_full;
  logic [4:0]           offset;
  logic                 in_window;
  logic                 eng_ready;
  logic                 busy;
  logic [31:0]          rx_data;
  logic [CHANNEL_W-1:0] wr_channel;

  // Addresses below the base wrap to large offsets and fall outside the window.
  assign offset_full = s_ctrlport_req_addr - BASE_ADDR;
  assign in_window   = offset_full < 20'(NUM_ADDRESSES);
  assign offset      = offset_full[4:0];
  assign wr_channel  = s_ctrlport_req_data[CHANNEL_POS +: CHANNEL_W];
  // The start pulse is in flight one cycle before the engine drops ready.
  assign busy        = !eng_ready || start_reg;

  always_ff @(posedge ctrlport_clk) begin
    resp_ack_reg <= 1'b0;
    start_reg    <= 1'b0;
    soft_rst_reg <= 1'b0;
    if (ctrlport_rst) begin
      tx_reg          <= '0;
      tms_reg         <= '0;
      presc_reg       <= PRESCALAR_W'(DEFAULT_PRESCALAR);
      length_reg      <= '0;
      sample_fall_reg <= 1'b0;
      channel_reg     <= '0;
      err_reg         <= '0;
      resp_status_reg <= STS_OKAY;
      resp_data_reg   <= '0;
    end else if ((s_ctrlport_req_wr || s_ctrlport_req_rd) && in_window) begin
      resp_ack_reg    <= 1'b1;
      resp_status_reg <= STS_OKAY;
      resp_data_reg   <= '0;
      if (s_ctrlport_req_wr) begin
        case (offset)
          REG_TX_DATA, REG_TMS_DATA: begin
            if (busy) begin
              resp_status_reg       <= STS_CMDERR;
              err_reg[ERR_BUSY_BIT] <= 1'b1;
            end else if (offset == REG_TX_DATA) begin
              tx_reg <= s_ctrlport_req_data;
            end else begin
              tms_reg <= s_ctrlport_req_data;
            end
          end
          REG_CONTROL: begin
            if (s_ctrlport_req_data[RESET_POS]) begin
              soft_rst_reg <= 1'b1;
            end else if (busy) begin
              resp_status_reg       <= STS_CMDERR;
              err_reg[ERR_BUSY_BIT] <= 1'b1;
            end else if ({1'b0, wr_channel} >= NUM_CH) begin
              resp_status_reg          <= STS_CMDERR;
              err_reg[ERR_CHANNEL_BIT] <= 1'b1;
            end else begin
              presc_reg       <= s_ctrlport_req_data[PRESCALAR_POS +: PRESCALAR_W];
              length_reg      <= s_ctrlport_req_data[LENGTH_POS +: LENGTH_W];
              sample_fall_reg <= s_ctrlport_req_data[SAMPLE_FALL_POS];
              channel_reg     <= wr_channel;
              start_reg       <= 1'b1;
            end
          end
          REG_ERROR: err_reg <= err_reg & ~s_ctrlport_req_data[ERROR_W-1:0];
          default:   resp_status_reg <= STS_CMDERR;
        endcase
      end else begin
        case (offset)
          REG_CONTROL: resp_data_reg <= pack_control(!busy, presc_reg, length_reg,
                                                     sample_fall_reg, channel_reg);
          REG_RX_DATA: resp_data_reg <= rx_data;
          REG_ERROR:   resp_data_reg <= {{(32-ERROR_W){1'b0}}, err_reg};
          default:     resp_status_reg <= STS_CMDERR;
        endcase
      end
    end
  end

  jtag_shift_engine #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .IDLE_TCK     (IDLE_TCK)
  ) u_engine (
    .ctrlport_clk (ctrlport_clk),
    .ctrlport_rst (ctrlport_rst),
    .start        (start_reg),
    .soft_rst     (soft_rst_reg),
    .tx_data      (tx_reg),
    .tms_data     (tms_reg),
    .prescalar    (presc_reg),
    .length       (length_reg),
    .sample_fall  (sample_fall_reg),
    .channel      (channel_reg),
    .ready        (eng_ready),
    .rx_data      (rx_data),
    .tck          (tck),
    .tdi          (tdi),
    .tms          (tms),
    .tdo          (tdo)
  );

  assign s_ctrlport_resp_ack    = resp_ack_reg;
  assign s_ctrlport_resp_status = resp_status_reg;
  assign s_ctrlport_resp_data   = resp_data_reg;

endmodule

// File: tb/tb_ctrlport_to_jtag_multi.sv
// Scoreboard bench for ctrlport_to_jtag_multi (two chains, chain 0 TDO looped
// back from TDI, chain 1 TDO driven by the bench).
module tb_ctrlport_to_jtag_multi;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] CMDERR = 2'd1;
  localparam logic [19:0] A_TX   = 20'h00;
  localparam logic [19:0] A_TMS  = 20'h04;
  localparam logic [19:0] A_CTRL = 20'h08;
  localparam logic [19:0] A_RX   = 20'h0C;
  localparam logic [19:0] A_ERR  = 20'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_wr = 1'b0;
  logic        req_rd = 1'b0;
  logic [19:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        resp_ack;
  logic [1:0]  resp_status;
  logic [31:0] resp_data;
  logic [1:0]  tck, tdi, tms, tdo;
  logic        tdo1_drv = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    bit          ack;
    logic [1:0]  status;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  assign tdo = {tdo1_drv, tdi[0]};

  ctrlport_to_jtag_multi dut (
    .ctrlport_clk           (clk),
    .ctrlport_rst           (rst),
    .s_ctrlport_req_wr      (req_wr),
    .s_ctrlport_req_rd      (req_rd),
    .s_ctrlport_req_addr    (req_addr),
    .s_ctrlport_req_data    (req_data),
    .s_ctrlport_resp_ack    (resp_ack),
    .s_ctrlport_resp_status (resp_status),
    .s_ctrlport_resp_data   (resp_data),
    .tck                    (tck),
    .tdi                    (tdi),
    .tms                    (tms),
    .tdo                    (tdo)
  );

  // Chain activity monitor, sampled on the falling clock edge.
  int rise0 = 0, rise1 = 0, hi0 = 0, hi1 = 0, act0 = 0;
  int run1 = 0, run1_min = 1000, run1_max = 0;
  logic tms_log0 [0:1023];
  logic tdi_log0 [0:1023];
  logic [1:0] tck_prev = 2'b00;

  always @(negedge clk) begin
    if (tck[0] === 1'b1 && tck_prev[0] === 1'b0) begin
      tms_log0[rise0 % 1024] = tms[0];
      tdi_log0[rise0 % 1024] = tdi[0];
      rise0++;
    end
    if (tck[1] === 1'b1 && tck_prev[1] === 1'b0) rise1++;
    if (tck[0] === 1'b1) hi0++;
    if (tck[1] === 1'b1) begin
      hi1++;
      run1++;
    end else if (tck_prev[1] === 1'b1) begin
      if (run1 < run1_min) run1_min = run1;
      if (run1 > run1_max) run1_max = run1;
      run1 = 0;
    end
    if ((tdi[0] | tms[0]) === 1'b1) act0++;
    tck_prev = tck;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One ControlPort transaction: queue the expectation, drive, then pop and compare on ack.
  task automatic xact(input string tag, input bit wr, input logic [19:0] addr,
                      input logic [31:0] wdata, input bit exp_ack,
                      input logic [1:0] exp_st, input logic [31:0] exp_data);
    exp_t e;
    bit seen;
    int lat;
    logic [1:0] st;
    logic [31:0] d;
    e.tag = tag; e.ack = exp_ack; e.status = exp_st; e.data = exp_data; e.chk_data = !wr;
    exp_q.push_back(e);
    req_wr = wr; req_rd = !wr; req_addr = addr; req_data = wdata;
    @(posedge clk); #1;
    req_wr = 1'b0; req_rd = 1'b0;
    seen = 1'b0; lat = 0; st = '0; d = '0;
    for (int i = 1; i <= 4 && !seen; i++) begin
      if (resp_ack === 1'b1) begin
        seen = 1'b1; lat = i; st = resp_status; d = resp_data;
      end else begin
        @(posedge clk); #1;
      end
    end
    e = exp_q.pop_front();
    check({e.tag, ".ack"}, 32'(seen), 32'(e.ack));
    if (seen && e.ack) begin
      check({e.tag, ".lat"}, lat, 1);
      check({e.tag, ".sts"}, 32'(st), 32'(e.status));
      if (e.chk_data) check({e.tag, ".data"}, d, e.data);
    end
    $display("xact %s wr=%0d addr=0x%05h ack=%0d sts=%0d data=0x%08h",
             e.tag, wr, addr, seen, st, d);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r1, h0, h1, a0;
    logic [7:0] tv, mv;
    bit found;

    // 1: reset state
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    check("rst.tck", 32'(tck), 32'h0);
    check("rst.tdi_tms", 32'({tdi, tms}), 32'h0);
    check("rst.ack", 32'(resp_ack), 32'h0);
    xact("t1.ctrl", 0, A_CTRL, 0, 1, OKAY, 32'h8000_0000);
    xact("t1.err", 0, A_ERR, 0, 1, OKAY, 32'h0);

    // 2: 8-bit loopback on chain 0
    r0 = rise0; r1 = rise1; h0 = hi0;
    xact("t2.tx", 1, A_TX, 32'hA5, 1, OKAY, 0);
    xact("t2.tms", 1, A_TMS, 32'h01, 1, OKAY, 0);
    xact("t2.ctrl", 1, A_CTRL, 32'h0000_0700, 1, OKAY, 0);
    wait_cyc(17);
    xact("t2.busy_end", 0, A_CTRL, 0, 1, OKAY, 32'h0000_0700);
    wait_cyc(3);
    xact("t2.ready", 0, A_CTRL, 0, 1, OKAY, 32'h8000_0700);
    xact("t2.rx", 0, A_RX, 0, 1, OKAY, 32'h0000_00A5);
    for (int i = 0; i < 8; i++) begin
      tv[i] = tdi_log0[(r0 + i) % 1024];
      mv[i] = tms_log0[(r0 + i) % 1024];
    end
    check("t2.rises0", rise0 - r0, 8);
    check("t2.hi0", hi0 - h0, 8);
    check("t2.rises1", rise1 - r1, 0);
    check("t2.tdi_bits", 32'(tv), 32'hA5);
    check("t2.tms_bits", 32'(mv), 32'h01);

    // 3: 32 bits on chain 1, prescalar 3, sample on falling edge
    tdo1_drv = 1'b1;
    r0 = rise0; r1 = rise1; h1 = hi1; a0 = act0;
    xact("t3.ctrl", 1, A_CTRL, 32'h0001_3F03, 1, OKAY, 0);
    wait_cyc(258);
    xact("t3.ready", 0, A_CTRL, 0, 1, OKAY, 32'h8001_3F03);
    xact("t3.rx", 0, A_RX, 0, 1, OKAY, 32'hFFFF_FFFF);
    check("t3.rises1", rise1 - r1, 32);
    check("t3.hi1", hi1 - h1, 128);
    check("t3.run_min", run1_min, 4);
    check("t3.run_max", run1_max, 4);
    check("t3.rises0", rise0 - r0, 0);
    check("t3.act0", act0 - a0, 0);
    tdo1_drv = 1'b0;

    // 4: write while busy is rejected and flagged
    xact("t4.ctrl", 1, A_CTRL, 32'h0000_0700, 1, OKAY, 0);
    xact("t4.tx_busy", 1, A_TX, 32'h3C, 1, CMDERR, 0);
    xact("t4.err", 0, A_ERR, 0, 1, OKAY, 32'h1);
    xact("t4.err_clr", 1, A_ERR, 32'h1, 1, OKAY, 0);
    xact("t4.err0", 0, A_ERR, 0, 1, OKAY, 32'h0);
    xact("t4.tx_rd", 0, A_TX, 0, 1, CMDERR, 32'h0);
    wait_cyc(25);
    xact("t4.ctrl2", 1, A_CTRL, 32'h0000_0700, 1, OKAY, 0);
    wait_cyc(25);
    xact("t4.rx", 0, A_RX, 0, 1, OKAY, 32'h0000_00A5);

    // 5: out-of-range channel
    r0 = rise0; r1 = rise1;
    xact("t5.ctrl", 1, A_CTRL, 32'h0002_0000, 1, CMDERR, 0);
    xact("t5.err", 0, A_ERR, 0, 1, OKAY, 32'h2);
    xact("t5.ready", 0, A_CTRL, 0, 1, OKAY, 32'h8000_0700);
    wait_cyc(10);
    check("t5.rises", (rise0 - r0) + (rise1 - r1), 0);
    xact("t5.err_clr", 1, A_ERR, 32'hFFFF_FFFF, 1, OKAY, 0);
    xact("t5.err0", 0, A_ERR, 0, 1, OKAY, 32'h0);

    // 6: soft reset mid-shift, then window edges
    xact("t6.tx", 1, A_TX, 32'h1234_5678, 1, OKAY, 0);
    xact("t6.ctrl", 1, A_CTRL, 32'h0000_1F03, 1, OKAY, 0);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (tck[0] === 1'b1) found = 1'b1;
      else wait_cyc(1);
    end
    check("t6.tck_seen", 32'(found), 32'h1);
    xact("t6.soft_rst", 1, A_CTRL, 32'h8000_0000, 1, OKAY, 0);
    wait_cyc(1);
    check("t6.idle_outs", 32'({tck, tdi, tms}), 32'h0);
    wait_cyc(1);
    xact("t6.ready", 0, A_CTRL, 0, 1, OKAY, 32'h8000_1F03);
    xact("t6.rx_kept", 0, A_RX, 0, 1, OKAY, 32'h0000_00A5);
    r0 = rise0;
    wait_cyc(40);
    check("t6.no_rises", rise0 - r0, 0);
    xact("t6.outside", 0, 20'h40, 0, 0, OKAY, 0);
    xact("t6.undef", 0, 20'h14, 0, 1, CMDERR, 32'h0);
    xact("t6.undef_wr", 1, 20'h1C, 32'h1, 1, CMDERR, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
